// File: rtl/fsm_start_ctrl.sv
// fsm_start_ctrl
//   Conditioning and launch stage in front of the sequence FSM. Synchronises
//   and debounces a raw active-low pushbutton and a raw slide switch, turns
//   each accepted press into a held start request that tracks the FSM's
//   idle/finish status, counts completed runs and flags unacknowledged launches.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   key_n      in   raw pushbutton, 0 = pressed
//   sw_in      in   raw slide switch
//   fsm_idle   in   idle status from the sequence FSM
//   fsm_finish in   finish status from the sequence FSM
//   start      out  launch request (registered)
//   sw_0       out  debounced switch level
//   busy       out  high whenever the controller is not in READY
//   start_err  out  sticky launch-timeout flag
//   run_count  out  completed runs, saturating at 255
`timescale 1ns/1ps
module fsm_start_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned START_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_n,
    input  logic       sw_in,
    input  logic       fsm_idle,
    input  logic       fsm_finish,
    output logic       start,
    output logic       sw_0,
    output logic       busy,
    output logic       start_err,
    output logic [7:0] run_count
);

    localparam int unsigned      TMO_W   = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(START_TIMEOUT);

    typedef enum logic [3:0] {
        S_READY  = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_RUN    = 4'b0100,
        S_DONE   = 4'b1000
    } state_e;

    logic             key_s1_q, key_s2_q, key_db_q, key_db_d;
    logic             sw_s1_q, sw_s2_q, sw_db_q, sw_db_d;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d, sw_cnt_q, sw_cnt_d;
    logic             press_q;
    logic             fin_prev_q, fin_rise;
    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             start_q, start_d, busy_q, busy_d, err_q, err_d;
    logic [7:0]       runs_q, runs_d;

    // Debounce: the counter runs only while the synchronised level disagrees
    // with the accepted level; any agreement clears it.
    always_comb begin
        key_cnt_d = '0;
        key_db_d  = key_db_q;
        if (key_s2_q != key_db_q) begin
            if (key_cnt_q == DB_LAST) key_db_d = key_s2_q;
            else                      key_cnt_d = key_cnt_q + 1'b1;
        end
    end

    always_comb begin
        sw_cnt_d = '0;
        sw_db_d  = sw_db_q;
        if (sw_s2_q != sw_db_q) begin
            if (sw_cnt_q == DB_LAST) sw_db_d = sw_s2_q;
            else                     sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    assign fin_rise = fsm_finish & ~fin_prev_q;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        runs_d  = runs_q;
        case (state_q)
            S_READY: begin
                if (press_q) begin
                    state_d = S_LAUNCH;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_LAUNCH: begin
                if (!fsm_idle) begin
                    state_d = S_RUN;
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_READY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RUN: begin
                if (fin_rise) begin
                    state_d = S_DONE;
                    if (runs_q != 8'hFF) runs_d = runs_q + 8'd1;
                end
            end
            S_DONE: begin
                if (fsm_idle) state_d = S_READY;
            end
            default: state_d = S_READY;
        endcase
        // Outputs are registered, so they are decoded from the next state.
        start_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_READY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            key_db_q   <= 1'b1;
            key_cnt_q  <= '0;
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            sw_db_q    <= 1'b0;
            sw_cnt_q   <= '0;
            press_q    <= 1'b0;
            fin_prev_q <= 1'b0;
            state_q    <= S_READY;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            runs_q     <= '0;
        end else begin
            key_s1_q   <= key_n;
            key_s2_q   <= key_s1_q;
            key_db_q   <= key_db_d;
            key_cnt_q  <= key_cnt_d;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            sw_db_q    <= sw_db_d;
            sw_cnt_q   <= sw_cnt_d;
            // One-cycle pulse in the cycle after the accepted level falls.
            press_q    <= key_db_q & ~key_db_d;
            fin_prev_q <= fsm_finish;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            runs_q     <= runs_d;
        end
    end

    assign start     = start_q;
    assign sw_0      = sw_db_q;
    assign busy      = busy_q;
    assign start_err = err_q;
    assign run_count = runs_q;

endmodule

// File: tb/tb_fsm_start_ctrl.sv
`timescale 1ns/1ps
module tb_fsm_start_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned TMO = 8;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DONE   = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       key_n = 1'b1;
    logic       sw_in = 1'b0;
    logic       fsm_idle = 1'b1;
    logic       fsm_finish = 1'b0;
    logic       start, sw_0, busy, start_err;
    logic [7:0] run_count;

    fsm_start_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(16),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_n(key_n),
        .sw_in(sw_in),
        .fsm_idle(fsm_idle),
        .fsm_finish(fsm_finish),
        .start(start),
        .sw_0(sw_0),
        .busy(busy),
        .start_err(start_err),
        .run_count(run_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    // Inputs reach the debouncer two edges late; a level is accepted once the
    // last DB synchronised samples all disagree with the accepted level.
    int m_phase = P_IDLE;
    int m_age = 0;
    int m_cnt = 0;
    bit m_press = 0, m_fin_last = 0, m_kdb = 1, m_sdb = 0, m_err = 0;
    bit k_hist[$] = '{1'b1, 1'b1};
    bit s_hist[$] = '{1'b0, 1'b0};
    bit k_win[$];
    bit s_win[$];

    function automatic bit all_differ(input bit w[$], input bit db);
        if (w.size() < DB) return 1'b0;
        foreach (w[i]) if (w[i] == db) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_cnt = 0;
        m_press = 0; m_fin_last = 0; m_kdb = 1; m_sdb = 0; m_err = 0;
        k_hist = '{1'b1, 1'b1};
        s_hist = '{1'b0, 1'b0};
        k_win.delete();
        s_win.delete();
    endtask

    always @(posedge clk or negedge reset_n) begin : mdl
        bit ks, ss, kold;
        if (!reset_n) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE:   if (m_press) begin m_phase = P_LAUNCH; m_err = 0; m_age = 0; end
                P_LAUNCH: if (!fsm_idle) m_phase = P_RUN;
                          else if (m_age == TMO) begin m_err = 1; m_phase = P_IDLE; end
                          else m_age++;
                P_RUN:    if (fsm_finish && !m_fin_last) begin
                              m_phase = P_DONE;
                              m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                          end
                default:  if (fsm_idle) m_phase = P_IDLE;
            endcase
            m_fin_last = fsm_finish;
            ks = k_hist[1];
            ss = s_hist[1];
            k_hist.push_front(key_n); void'(k_hist.pop_back());
            s_hist.push_front(sw_in); void'(s_hist.pop_back());
            k_win.push_back(ks); if (k_win.size() > DB) void'(k_win.pop_front());
            s_win.push_back(ss); if (s_win.size() > DB) void'(s_win.pop_front());
            kold = m_kdb;
            if (all_differ(k_win, m_kdb)) m_kdb = ks;
            if (all_differ(s_win, m_sdb)) m_sdb = ss;
            m_press = kold && !m_kdb;
        end
    end

    // ---------------- responder standing in for the sequence FSM ----------------
    int rph = 0, rcnt = 0;
    bit resp_stuck = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rph = 0; fsm_idle = 1'b1; fsm_finish = 1'b0;
        end else begin
            #1;
            if (!resp_stuck) begin
                case (rph)
                    0: if (start) rph = 4;
                    4: begin fsm_idle = 1'b0; rcnt = 0; rph = 1; end
                    1: begin rcnt++; if (rcnt == 16) begin fsm_finish = 1'b1; rph = 2; end end
                    2: begin fsm_finish = 1'b0; fsm_idle = 1'b1; rph = 0; end
                    default: rph = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare and start monitor ----------------
    int cyc_n = 0;
    int start_rises = 0, hi_len = 0, last_hi_len = 0, rise_cyc = 0;
    bit start_prev = 0;
    bit cmp_on = 0;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_start", start, m_phase == P_LAUNCH);
            chk("cyc_busy", busy, m_phase != P_IDLE);
            chk("cyc_sw_0", sw_0, m_sdb);
            chk("cyc_start_err", start_err, m_err);
            chk("cyc_run_count", run_count, m_cnt);
        end
        if (start && !start_prev) begin start_rises++; rise_cyc = cyc_n; hi_len = 0; end
        if (start) hi_len++;
        if (!start && start_prev) last_hi_len = hi_len;
        start_prev = start;
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin cyc(1); k++; end
        chk(name, busy, 0);
        cyc(2);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, n0;
        #1 reset_n = 1'b0;
        #1 cmp_on = 1'b1;
        cyc(3);
        reset_n = 1'b1;

        // 1: idle after reset
        cyc(20);
        chk("t1_start", start, 0);
        chk("t1_busy", busy, 0);
        chk("t1_sw_0", sw_0, 0);
        chk("t1_run_count", run_count, 0);
        chk("t1_start_err", start_err, 0);

        // 2: bounce rejected, then a clean hold launches after 7 cycles
        repeat (5) begin key_n = 1'b0; cyc(2); key_n = 1'b1; cyc(2); end
        cyc(8);
        chk("t2_bounce_rises", start_rises, 0);
        c0 = cyc_n;
        key_n = 1'b0;
        cyc(10);
        chk("t2_rise_delay", rise_cyc - c0, 7);
        chk("t2_rises", start_rises, 1);
        key_n = 1'b1;

        // 3: full run completes
        wait_idle("t3_idle");
        chk("t3_start_len", last_hi_len, 2);
        chk("t3_run_count", run_count, 1);
        chk("t3_rises", start_rises, 1);

        // 4: FSM never acknowledges -> timeout
        resp_stuck = 1;
        key_n = 1'b0; cyc(10); key_n = 1'b1; cyc(14);
        chk("t4_start_len", last_hi_len, 9);
        chk("t4_start", start, 0);
        chk("t4_start_err", start_err, 1);
        chk("t4_busy", busy, 0);
        resp_stuck = 0;
        key_n = 1'b0; cyc(10);
        chk("t4_err_cleared", start_err, 0);
        key_n = 1'b1;
        wait_idle("t4_idle");
        chk("t4_run_count", run_count, 2);

        // 5: press during RUN is dropped, then saturate the run counter
        r0 = start_rises;
        key_n = 1'b0; cyc(10); key_n = 1'b1; cyc(5);
        key_n = 1'b0; cyc(6); key_n = 1'b1;
        wait_idle("t5_idle");
        cyc(12);
        chk("t5_single_launch", start_rises - r0, 1);
        chk("t5_run_count", run_count, 3);
        for (int i = 0; i < 300; i++) begin
            key_n = 1'b0; cyc(8); key_n = 1'b1; cyc(6);
            wait_idle("t5_loop_idle");
        end
        chk("t5_saturated", run_count, 255);

        // 6: switch glitches rejected, stable change accepted
        repeat (4) begin sw_in = 1'b1; cyc(1); sw_in = 1'b0; cyc(3); end
        chk("t6_sw_glitch", sw_0, 0);
        sw_in = 1'b1; cyc(6);
        chk("t6_sw_follow", sw_0, 1);

        // 6: reset in the middle of a run
        key_n = 1'b0; cyc(10); key_n = 1'b1; cyc(4);
        chk("t6_busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_start", start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_sw_0", sw_0, 0);
        chk("t6_rst_start_err", start_err, 0);
        chk("t6_rst_run_count", run_count, 0);
        key_n = 1'b0;
        cyc(3);
        n0 = start_rises;
        c0 = cyc_n;
        reset_n = 1'b1;
        cyc(30);
        chk("t6_post_reset_rises", start_rises - n0, 1);
        chk("t6_post_reset_delay", rise_cyc - c0, 7);
        key_n = 1'b1;
        wait_idle("t6_idle");
        chk("t6_run_count", run_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
